axi_wr_slave: RTL and testbench
===============================

# axi_wr_slave

AXI write-channel responder, the slave end of the write path whose traffic the protocol checker monitors. It accepts one INCR burst at a time on AW/W, forwards each beat to a simple memory write port, and returns a single B response per burst. It sits between the AXI interconnect and local SRAM/register storage.

## Interface

- ADDR_WIDTH, 32, AXI address width
- DATA_WIDTH, 128, AXI data width (power of two, ≥ 32); BYTES = DATA_WIDTH/8
- ADDR_BASE, 32'h0000_0000, first byte address owned by this slave
- ADDR_SIZE, 32'h0001_0000, owned window size in bytes

- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- axi_awvalid  in  1  write address valid
- axi_awready  out  1  write address ready
- axi_awaddr  in  ADDR_WIDTH  burst start byte address
- axi_awlen  in  8  beats minus one (INCR only)
- axi_wvalid  in  1  write data valid
- axi_wready  out  1  write data ready
- axi_wdata  in  DATA_WIDTH  write data
- axi_wstrb  in  BYTES  byte strobes
- axi_wlast  in  1  last beat marker
- axi_bvalid  out  1  response valid
- axi_bready  in  1  response ready
- axi_bresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  beat byte address (BYTES-aligned)
- mem_wdata  out  DATA_WIDTH  beat data
- mem_wstrb  out  BYTES  beat strobes
- mem_ready  in  1  memory can accept a write this cycle
- busy  out  1  high whenever state ≠ IDLE

## Operation

- FSM states IDLE, DATA, RESP; reset → IDLE.
- IDLE: axi_awready=1. AW handshake latches aligned address (awaddr with low log2(BYTES) bits cleared), beat counter = awlen, clears err; → DATA.
- Range check at AW handshake: SLVERR flag set if aligned start < ADDR_BASE or aligned start + (awlen+1)*BYTES > ADDR_BASE+ADDR_SIZE (compute in ADDR_WIDTH+9 bits, no wrap).
- DATA: axi_wready = mem_ready. W handshake = axi_wvalid & axi_wready. mem_we = handshake & ~range_err (combinational); mem_addr/wdata/wstrb driven from current beat address and W bus. Beat address += BYTES per handshake, wraps modulo 2^ADDR_WIDTH. On handshake with counter==0 → RESP, else counter−1.
- RESP: axi_bvalid=1, axi_bresp = SLVERR if range_err or wlast_err, else OKAY; bresp stable while bvalid high. bvalid & bready → IDLE.
- W beats are never accepted in IDLE or RESP (wready=0); W arriving before AW waits.
- Only one outstanding burst; AW not accepted until B handshake completes.

## Timing

- Reset values: axi_awready=0, axi_wready=0, axi_bvalid=0, axi_bresp=2'b00, mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, busy=0. axi_awready rises after first clock edge following rst_n release.
- AW handshake at cycle T → DATA at T+1 (wready may be 1 at T+1).
- Final W handshake at cycle T → bvalid=1 at T+1.
- B handshake at cycle T → awready=1 at T+1. Minimum single-beat transaction: 3 cycles AW-to-next-awready.
- mem_ready low: wready low same cycle, no beat consumed, counter/address hold.
- rst_n asserted mid-burst: immediate return to IDLE, all outputs to reset values, partial burst dropped, no B issued.

## Configuration

- AXI_WR_SLAVE_WLAST_CHK_EN defined: wlast_err set if axi_wlast=1 on a non-final handshake or 0 on the final handshake; burst still ends on beat count; response SLVERR.
- Not defined: axi_wlast ignored, wlast_err constant 0; burst length from awlen only.

## Test plan

- Single beat: awaddr=0x100, awlen=0, wdata=0xA5.., wlast=1, bready=1 → mem_we one cycle at addr 0x100, bvalid one cycle after W handshake, bresp=00.
- 4-beat burst awaddr=0x20F, mem_ready toggling 1,0,1,0 → mem_addr 0x200,0x210,0x220,0x230, wready tracks mem_ready, exactly 4 mem_we pulses, bresp=00.
- Out of range: awaddr=ADDR_BASE+ADDR_SIZE−BYTES, awlen=1 → both beats accepted, mem_we never asserted, bresp=10.
- bready held 0 for 20 cycles → bvalid/bresp stable, awready 0 throughout, awready=1 cycle after bready.
- WLAST_CHK_EN: awlen=3 with wlast on beat 2 → 4 beats consumed, bresp=10; macro undefined same stimulus → bresp=00.
- rst_n pulsed low after 2 of 4 beats → outputs at reset values, no bvalid; new awlen=0 burst completes with bresp=00.

Source files
------------

// File: rtl/axi_wr_slave.sv
// AXI write-channel slave: one INCR burst at a time, beats forwarded to a memory write port.
// Optional AXI_WR_SLAVE_WLAST_CHK_EN flags WLAST placement errors as SLVERR.
module axi_wr_slave #(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 128,
   parameter logic [ADDR_WIDTH-1:0] ADDR_BASE  = 32'h0000_0000,
   parameter logic [ADDR_WIDTH-1:0] ADDR_SIZE  = 32'h0001_0000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      axi_awvalid,
   output logic                      axi_awready,
   input  logic [ADDR_WIDTH-1:0]     axi_awaddr,
   input  logic [7:0]                axi_awlen,
   input  logic                      axi_wvalid,
   output logic                      axi_wready,
   input  logic [DATA_WIDTH-1:0]     axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]   axi_wstrb,
   input  logic                      axi_wlast,
   output logic                      axi_bvalid,
   input  logic                      axi_bready,
   output logic [1:0]                axi_bresp,
   output logic                      mem_we,
   output logic [ADDR_WIDTH-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0]     mem_wdata,
   output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
   input  logic                      mem_ready,
   output logic                      busy
);

   // state | meaning
   // IDLE  | waiting for AW handshake (awready high once out of reset)
   // DATA  | accepting W beats while mem_ready is high
   // RESP  | holding B response until bready
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int WIDE  = ADDR_WIDTH + 9;

   state_t                  state_q, state_d;
   logic                    init_q, init_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [7:0]              cnt_q, cnt_d;
   logic                    range_err_q, range_err_d;
   logic                    wlast_err_q, wlast_err_d;

   logic [ADDR_WIDTH-1:0]   aligned;
   logic [WIDE-1:0]         start_w, end_w, limit_w;
   logic                    range_bad;
   logic                    aw_hs, w_hs;

   // Range math is widened so a burst running past the top of the address space cannot wrap back in.
   always_comb begin
      aligned   = axi_awaddr & ~ADDR_WIDTH'(BYTES - 1);
      start_w   = WIDE'(aligned);
      end_w     = start_w + (WIDE'(axi_awlen) + WIDE'(1)) * WIDE'(BYTES);
      limit_w   = WIDE'(ADDR_BASE) + WIDE'(ADDR_SIZE);
      range_bad = (start_w < WIDE'(ADDR_BASE)) || (end_w > limit_w);
   end

   always_comb begin
      axi_awready = init_q && (state_q == IDLE);
      axi_wready  = (state_q == DATA) && mem_ready;
      aw_hs       = axi_awvalid && axi_awready;
      w_hs        = axi_wvalid && axi_wready;
      mem_we      = w_hs && !range_err_q;
      mem_addr    = addr_q;
      mem_wdata   = (state_q == DATA) ? axi_wdata : '0;
      mem_wstrb   = (state_q == DATA) ? axi_wstrb : '0;
      axi_bvalid  = (state_q == RESP);
      axi_bresp   = ((state_q == RESP) && (range_err_q || wlast_err_q)) ? 2'b10 : 2'b00;
      busy        = (state_q != IDLE);
   end

`ifndef AXI_WR_SLAVE_WLAST_CHK_EN
   logic unused_wlast;
   assign unused_wlast = axi_wlast;
`endif

   always_comb begin
      state_d     = state_q;
      init_d      = 1'b1;
      addr_d      = addr_q;
      cnt_d       = cnt_q;
      range_err_d = range_err_q;
      wlast_err_d = wlast_err_q;
      case (state_q)
         IDLE: begin
            if (aw_hs) begin
               addr_d      = aligned;
               cnt_d       = axi_awlen;
               range_err_d = range_bad;
               wlast_err_d = 1'b0;
               state_d     = DATA;
            end
         end
         DATA: begin
            if (w_hs) begin
               addr_d = addr_q + ADDR_WIDTH'(BYTES);
`ifdef AXI_WR_SLAVE_WLAST_CHK_EN
               if (axi_wlast != (cnt_q == 8'd0))
                  wlast_err_d = 1'b1;
`endif
               if (cnt_q == 8'd0)
                  state_d = RESP;
               else
                  cnt_d = cnt_q - 8'd1;
            end
         end
         RESP: begin
            if (axi_bready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         init_q      <= 1'b0;
         addr_q      <= '0;
         cnt_q       <= '0;
         range_err_q <= 1'b0;
         wlast_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_q      <= init_d;
         addr_q      <= addr_d;
         cnt_q       <= cnt_d;
         range_err_q <= range_err_d;
         wlast_err_q <= wlast_err_d;
      end
   end

endmodule

// File: tb/tb_axi_wr_slave.sv
// Directed bench for axi_wr_slave: table of bursts plus hand sequences for reset behaviour.
module tb_axi_wr_slave;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          axi_awvalid, axi_awready;
   logic [31:0]   axi_awaddr;
   logic [7:0]    axi_awlen;
   logic          axi_wvalid, axi_wready;
   logic [127:0]  axi_wdata;
   logic [15:0]   axi_wstrb;
   logic          axi_wlast;
   logic          axi_bvalid, axi_bready;
   logic [1:0]    axi_bresp;
   logic          mem_we;
   logic [31:0]   mem_addr;
   logic [127:0]  mem_wdata;
   logic [15:0]   mem_wstrb;
   logic          mem_ready;
   logic          busy;

   int total = 0;
   int bad   = 0;

`ifdef AXI_WR_SLAVE_WLAST_CHK_EN
   localparam logic [1:0] WL_RESP = 2'b10;
`else
   localparam logic [1:0] WL_RESP = 2'b00;
`endif

   axi_wr_slave dut (
      .clk(clk), .rst_n(rst_n),
      .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen),
      .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
      .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_bresp(axi_bresp),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          len;
      logic [15:0] rdy;      // mem_ready per data cycle, bit 0 first
      int          bad_last; // beat index whose wlast is inverted, -1 none
      int          bdly;     // cycles bready held low after bvalid
      logic        rerr;
      logic [1:0]  resp;
      int          nwe;
   } vec_t;

   vec_t vecs[7];

   function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endfunction

   task automatic run_burst(input vec_t v);
      int k, cyc, nwe;
      logic [31:0] base;
      logic got;
      base = v.addr & ~32'hF;
      axi_awaddr  = v.addr;
      axi_awlen   = 8'(v.len);
      axi_awvalid = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         @(negedge clk);
         got = axi_awready;
         @(posedge clk); #1;
      end
      axi_awvalid = 1'b0;
      chk("aw_handshake", got, 1'b1);
      k = 0; cyc = 0; nwe = 0;
      axi_wvalid = 1'b1;
      while (k <= v.len && cyc < 200) begin
         mem_ready = v.rdy[cyc % 16];
         axi_wdata = {4{32'hA5A5_0000 | 32'(k)}};
         axi_wstrb = 16'hFFFF ^ 16'(k);
         axi_wlast = (k == v.len) ^ (k == v.bad_last);
         @(negedge clk);
         chk("wready", axi_wready, mem_ready);
         chk("mem_we", mem_we, mem_ready & ~v.rerr);
         chk("bvalid_in_data", axi_bvalid, 1'b0);
         chk("busy_in_data", busy, 1'b1);
         if (mem_we) nwe++;
         if (mem_ready) begin
            chk("mem_addr", mem_addr, base + 32'(16 * k));
            chk("mem_wdata", mem_wdata, {4{32'hA5A5_0000 | 32'(k)}});
            chk("mem_wstrb", mem_wstrb, 16'hFFFF ^ 16'(k));
         end
         @(posedge clk); #1;
         if (mem_ready) k++;
         cyc++;
      end
      axi_wvalid = 1'b0;
      axi_wlast  = 1'b0;
      mem_ready  = 1'b1;
      chk("beats_done", k, v.len + 1);
      @(negedge clk);
      chk("bvalid_after_last", axi_bvalid, 1'b1);
      chk("bresp", axi_bresp, v.resp);
      chk("we_count", nwe, v.nwe);
      chk("awready_in_resp", axi_awready, 1'b0);
      for (int i = 0; i < v.bdly; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bvalid_hold", axi_bvalid, 1'b1);
         chk("bresp_hold", axi_bresp, v.resp);
         chk("awready_hold", axi_awready, 1'b0);
      end
      axi_bready = 1'b1;
      @(posedge clk); #1;
      axi_bready = 1'b0;
      @(negedge clk);
      chk("bvalid_cleared", axi_bvalid, 1'b0);
      chk("awready_after_b", axi_awready, 1'b1);
      chk("busy_after_b", busy, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      vecs[0] = '{32'h0000_0100, 0, 16'hFFFF, -1, 0,  1'b0, 2'b00, 1};
      vecs[1] = '{32'h0000_020F, 3, 16'h5555, -1, 0,  1'b0, 2'b00, 4};
      vecs[2] = '{32'h0000_FFF0, 1, 16'hFFFF, -1, 0,  1'b1, 2'b10, 0};
      vecs[3] = '{32'h0000_FFE0, 1, 16'hFFFF, -1, 0,  1'b0, 2'b00, 2};
      vecs[4] = '{32'h0000_0040, 0, 16'hFFFF, -1, 20, 1'b0, 2'b00, 1};
      vecs[5] = '{32'h0000_0400, 3, 16'hFFFF, 1,  0,  1'b0, WL_RESP, 4};
      vecs[6] = '{32'h0000_0300, 1, 16'hFFFF, 1,  0,  1'b0, WL_RESP, 2};

      rst_n = 1'b0;
      axi_awvalid = 1'b0; axi_awaddr = 32'h1234_5678; axi_awlen = 8'h0;
      axi_wvalid = 1'b1; axi_wdata = {4{32'hDEAD_BEEF}}; axi_wstrb = 16'hFFFF;
      axi_wlast = 1'b0; axi_bready = 1'b0; mem_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_awready", axi_awready, 1'b0);
      chk("rst_wready", axi_wready, 1'b0);
      chk("rst_bvalid", axi_bvalid, 1'b0);
      chk("rst_bresp", axi_bresp, 2'b00);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 128'h0);
      chk("rst_mem_wstrb", mem_wstrb, 16'h0);
      chk("rst_busy", busy, 1'b0);
      axi_wvalid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("awready_before_edge", axi_awready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("awready_after_edge", axi_awready, 1'b1);
      @(posedge clk); #1;

      for (int i = 0; i < 7; i++)
         run_burst(vecs[i]);

      // reset in the middle of a 4-beat burst
      axi_awaddr = 32'h0; axi_awlen = 8'd3; axi_awvalid = 1'b1;
      @(posedge clk); #1;
      axi_awvalid = 1'b0;
      axi_wvalid = 1'b1; mem_ready = 1'b1; axi_wdata = {4{32'h1111_2222}};
      repeat (2) begin
         @(negedge clk);
         chk("mid_we", mem_we, 1'b1);
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_awready", axi_awready, 1'b0);
      chk("mid_rst_wready", axi_wready, 1'b0);
      chk("mid_rst_mem_we", mem_we, 1'b0);
      chk("mid_rst_mem_addr", mem_addr, 32'h0);
      chk("mid_rst_mem_wdata", mem_wdata, 128'h0);
      chk("mid_rst_bvalid", axi_bvalid, 1'b0);
      chk("mid_rst_busy", busy, 1'b0);
      axi_wvalid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("no_b_after_rst", axi_bvalid, 1'b0);
         @(posedge clk); #1;
      end
      run_burst('{32'h0000_0080, 0, 16'hFFFF, -1, 0, 1'b0, 2'b00, 1});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
